// File: rtl/rcp_parser_if.sv
// Tapped NetFPGA user-data-path bus: one word per cycle when in_wr is high.
interface rcp_parser_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_wr;

  modport master (output in_data, output in_ctrl, output in_wr);
  modport slave  (input  in_data, input  in_ctrl, input  in_wr);
endinterface

// File: rtl/rcp_parser.sv
// Passive RCP header tap: follows each packet on the bus and extracts
// output port, byte length, IP protocol and RCP RTT for the accumulator.
module rcp_parser #(
  parameter int                   DATA_WIDTH    = 64,
  parameter int                   CTRL_WIDTH    = 8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL     = 8'hFF,
  parameter logic [7:0]           RCP_PROTO_NUM = 8'hFE
) (
  input  logic        clk,
  input  logic        reset_n,
  rcp_parser_if.slave bus,
  output logic        is_rcp,
  output logic [15:0] rcp_out_port,
  output logic [15:0] rcp_rtt,
  output logic [7:0]  rcp_proto,
  output logic [15:0] rcp_packet_length,
  output logic        rcp_out_port_vld,
  output logic        rcp_packet_length_vld,
  output logic        rcp_proto_vld,
  output logic        rcp_rtt_vld
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDRS, S_W2, S_W3, S_W4, S_W5, S_PAYLOAD
  } state_t;

  state_t      state_q, state_d;
  logic        ip_ok_q, ip_ok_d;
  logic        is_rcp_q, is_rcp_d;
  logic [15:0] out_port_q, out_port_d;
  logic [15:0] rtt_q, rtt_d;
  logic [7:0]  proto_q, proto_d;
  logic [15:0] len_q, len_d;
  logic        port_vld_q, port_vld_d;
  logic        len_vld_q, len_vld_d;
  logic        proto_vld_q, proto_vld_d;
  logic        rtt_vld_q, rtt_vld_d;

  logic hdr, eop;
  assign hdr = (bus.in_ctrl == IOQ_CTRL);
  // any non-zero ctrl after word 1 marks the last word of the packet
  assign eop = (bus.in_ctrl != '0);

  // bytes of the word that no field uses
  logic unused_data;
  assign unused_data = ^bus.in_data[DATA_WIDTH-17:32];

  // next-state and field capture; a header always restarts parsing
  always_comb begin
    state_d     = state_q;
    ip_ok_d     = ip_ok_q;
    is_rcp_d    = is_rcp_q;
    out_port_d  = out_port_q;
    rtt_d       = rtt_q;
    proto_d     = proto_q;
    len_d       = len_q;
    port_vld_d  = 1'b0;
    len_vld_d   = 1'b0;
    proto_vld_d = 1'b0;
    rtt_vld_d   = 1'b0;
    if (bus.in_wr) begin
      if (hdr) begin
        out_port_d = bus.in_data[DATA_WIDTH-1 -: 16];
        len_d      = bus.in_data[15:0];
        port_vld_d = 1'b1;
        len_vld_d  = 1'b1;
        is_rcp_d   = 1'b0;
        ip_ok_d    = 1'b0;
        state_d    = S_HDRS;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_HDRS: if (!eop) state_d = S_W2;
          S_W2: begin
            ip_ok_d = (bus.in_data[31:16] == 16'h0800) && (bus.in_data[15:8] == 8'h45);
            state_d = eop ? S_IDLE : S_W3;
          end
          S_W3: begin
            proto_d     = bus.in_data[7:0];
            proto_vld_d = 1'b1;
            state_d     = eop ? S_IDLE : S_W4;
          end
          S_W4: state_d = eop ? S_IDLE : S_W5;
          S_W5: begin
            if (ip_ok_q && proto_q == RCP_PROTO_NUM) begin
              rtt_d     = bus.in_data[31:16];
              rtt_vld_d = 1'b1;
              is_rcp_d  = 1'b1;
            end
            state_d = eop ? S_IDLE : S_PAYLOAD;
          end
          S_PAYLOAD: if (eop) state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // state and output registers; reset abandons any packet in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ip_ok_q     <= 1'b0;
      is_rcp_q    <= 1'b0;
      out_port_q  <= '0;
      rtt_q       <= '0;
      proto_q     <= '0;
      len_q       <= '0;
      port_vld_q  <= 1'b0;
      len_vld_q   <= 1'b0;
      proto_vld_q <= 1'b0;
      rtt_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ip_ok_q     <= ip_ok_d;
      is_rcp_q    <= is_rcp_d;
      out_port_q  <= out_port_d;
      rtt_q       <= rtt_d;
      proto_q     <= proto_d;
      len_q       <= len_d;
      port_vld_q  <= port_vld_d;
      len_vld_q   <= len_vld_d;
      proto_vld_q <= proto_vld_d;
      rtt_vld_q   <= rtt_vld_d;
    end
  end

  assign is_rcp                = is_rcp_q;
  assign rcp_out_port          = out_port_q;
  assign rcp_rtt               = rtt_q;
  assign rcp_proto             = proto_q;
  assign rcp_packet_length     = len_q;
  assign rcp_out_port_vld      = port_vld_q;
  assign rcp_packet_length_vld = len_vld_q;
  assign rcp_proto_vld         = proto_vld_q;
  assign rcp_rtt_vld           = rtt_vld_q;

endmodule

// File: tb/tb_rcp_parser.sv
// Bench for rcp_parser: builds a cycle stream of directed and random packets,
// derives expected outputs per cycle from a packet-level scan, then replays it.
module tb_rcp_parser;
  localparam int MAXN = 6000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rcp_parser_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) bus ();

  logic        is_rcp, port_vld, len_vld, proto_vld, rtt_vld;
  logic [15:0] out_port, rtt, len;
  logic [7:0]  proto;

  rcp_parser dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .is_rcp(is_rcp), .rcp_out_port(out_port), .rcp_rtt(rtt),
    .rcp_proto(proto), .rcp_packet_length(len),
    .rcp_out_port_vld(port_vld), .rcp_packet_length_vld(len_vld),
    .rcp_proto_vld(proto_vld), .rcp_rtt_vld(rtt_vld)
  );

  // stimulus stream
  logic        st_wr  [MAXN];
  logic        st_rst [MAXN];
  logic [7:0]  st_ctrl[MAXN];
  logic [63:0] st_data[MAXN];
  int          n = 0;

  // events and expected outputs after the edge that samples entry k
  logic        ev_hdr[MAXN], ev_proto[MAXN], ev_rtt[MAXN];
  logic [15:0] e_port[MAXN], e_len[MAXN], e_rtt[MAXN];
  logic [7:0]  e_proto[MAXN];
  logic        e_isrcp[MAXN], e_pv[MAXN], e_lv[MAXN], e_prv[MAXN], e_rv[MAXN];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input logic wr, input logic rst, input logic [7:0] ctrl, input logic [63:0] data);
    if (n < MAXN) begin
      st_wr[n] = wr; st_rst[n] = rst; st_ctrl[n] = ctrl; st_data[n] = data;
      n++;
    end
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++)
      push(1'b0, 1'b0, 8'($urandom), {$urandom, $urandom});
  endtask

  // one packet: header, optional module headers, nw data words; gap<0 picks
  // random gaps and random extra headers; rst_at asserts reset on that word
  task automatic add_pkt(input logic [15:0] port, input logic [15:0] plen,
                         input logic [7:0] pr, input logic [15:0] eth,
                         input logic [7:0] vihl, input logic [15:0] prtt,
                         input int nw, input int gap, input int rst_at, input bit eop);
    int xh;
    logic [63:0] d;
    xh = (gap < 0) ? int'($urandom_range(0, 2)) : 0;
    push(1'b1, 1'b0, 8'hFF, {port, 32'($urandom), plen});
    idle(gap < 0 ? int'($urandom_range(0, 2)) : gap);
    for (int i = 0; i < xh; i++) begin
      push(1'b1, 1'b0, 8'($urandom_range(1, 254)), {$urandom, $urandom});
      idle(gap < 0 ? int'($urandom_range(0, 2)) : gap);
    end
    for (int w = 1; w <= nw; w++) begin
      d = {$urandom, $urandom};
      if (w == 2) begin d[31:16] = eth; d[15:8] = vihl; end
      if (w == 3) d[7:0] = pr;
      if (w == 5) d[31:16] = prtt;
      push(1'b1, w == rst_at, (w == nw && eop) ? 8'($urandom_range(1, 254)) : 8'h00, d);
      idle(gap < 0 ? int'($urandom_range(0, 2)) : gap);
    end
  endtask

  // reference: find each packet, number its data words, decide its events,
  // then fold events into held values per cycle
  task automatic build_model();
    int w;
    logic ipok;
    logic [7:0] pr;
    logic [15:0] p, l, r;
    logic [7:0] q;
    logic ir;
    for (int k = 0; k < n; k++) begin
      ev_hdr[k] = 0; ev_proto[k] = 0; ev_rtt[k] = 0;
    end
    for (int k = 0; k < n; k++) begin
      if (st_wr[k] && !st_rst[k] && st_ctrl[k] == 8'hFF) begin
        ev_hdr[k] = 1; w = 0; ipok = 0; pr = 0;
        for (int j = k + 1; j < n; j++) begin
          if (st_rst[j]) break;
          if (!st_wr[j]) continue;
          if (st_ctrl[j] == 8'hFF) break;
          if (w == 0) begin
            if (st_ctrl[j] == 8'h00) w = 1;
            continue;
          end
          w++;
          if (w == 2) ipok = (st_data[j][31:16] == 16'h0800) && (st_data[j][15:8] == 8'h45);
          if (w == 3) begin ev_proto[j] = 1; pr = st_data[j][7:0]; end
          if (w == 5 && ipok && pr == 8'hFE) ev_rtt[j] = 1;
          if (st_ctrl[j] != 8'h00) break;
        end
      end
    end
    p = 0; l = 0; r = 0; q = 0; ir = 0;
    for (int k = 0; k < n; k++) begin
      e_pv[k] = 0; e_lv[k] = 0; e_prv[k] = 0; e_rv[k] = 0;
      if (st_rst[k]) begin
        p = 0; l = 0; r = 0; q = 0; ir = 0;
      end else begin
        if (ev_hdr[k]) begin
          p = st_data[k][63:48]; l = st_data[k][15:0]; ir = 0;
          e_pv[k] = 1; e_lv[k] = 1;
        end
        if (ev_proto[k]) begin q = st_data[k][7:0]; e_prv[k] = 1; end
        if (ev_rtt[k]) begin r = st_data[k][31:16]; ir = 1; e_rv[k] = 1; end
      end
      e_port[k] = p; e_len[k] = l; e_rtt[k] = r; e_proto[k] = q; e_isrcp[k] = ir;
    end
  endtask

  function automatic logic [15:0] rnd_port();
    logic [15:0] ports [4] = '{16'h0001, 16'h0004, 16'h0010, 16'h0040};
    return ports[$urandom_range(0, 3)];
  endfunction

  initial begin
    int kind, nw;
    logic [7:0] pr;
    logic [15:0] eth;
    logic [7:0] vihl;
    reset_n = 1'b0; bus.in_wr = 1'b0; bus.in_ctrl = '0; bus.in_data = '0;

    for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 8'h00, 64'h0);
    idle(2);
    // RCP back-to-back
    add_pkt(16'h0004, 16'd100, 8'hFE, 16'h0800, 8'h45, 16'h1234, 8, 0, 0, 1);
    idle(4);
    // non-RCP protocol
    add_pkt(16'h0001, 16'd64, 8'h06, 16'h0800, 8'h45, 16'hAAAA, 7, 0, 0, 1);
    idle(2);
    // RCP with two idle cycles between words
    add_pkt(16'h0010, 16'd200, 8'hFE, 16'h0800, 8'h45, 16'h5678, 7, 2, 0, 1);
    // EOP on word 4, then a valid RCP packet straight after
    add_pkt(16'h0040, 16'd80, 8'hFE, 16'h0800, 8'h45, 16'hDEAD, 4, 0, 0, 1);
    add_pkt(16'h0001, 16'd90, 8'hFE, 16'h0800, 8'h45, 16'hBEEF, 6, 0, 0, 1);
    // ARP ethertype carrying 0xFE in the protocol slot
    add_pkt(16'h0004, 16'd60, 8'hFE, 16'h0806, 8'h45, 16'h1111, 6, 0, 0, 1);
    // reset during W4, then a normal RCP packet
    add_pkt(16'h0010, 16'd70, 8'hFE, 16'h0800, 8'h45, 16'h2222, 7, 0, 4, 1);
    idle(3);
    add_pkt(16'h0040, 16'd110, 8'hFE, 16'h0800, 8'h45, 16'h3333, 6, 0, 0, 1);
    // packet cut short by a new header, no EOP seen
    add_pkt(16'h0001, 16'd50, 8'hFE, 16'h0800, 8'h45, 16'h4444, 4, 0, 0, 0);
    add_pkt(16'h0004, 16'd120, 8'hFE, 16'h0800, 8'h45, 16'h5555, 5, 0, 0, 1);
    idle(2);

    for (int i = 0; i < 70; i++) begin
      kind = $urandom_range(0, 5);
      pr   = (kind == 1) ? 8'($urandom_range(0, 253)) : 8'hFE;
      eth  = (kind == 2) ? 16'h86DD : 16'h0800;
      vihl = (kind == 3) ? 8'h46 : 8'h45;
      nw   = (kind == 4) ? int'($urandom_range(2, 5)) : int'($urandom_range(5, 9));
      add_pkt(rnd_port(), 16'($urandom), pr, eth, vihl, 16'($urandom), nw, -1,
              (kind == 5) ? int'($urandom_range(1, 6)) : 0, $urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) push(1'b1, 1'b0, 8'h00, {$urandom, $urandom});
      idle($urandom_range(0, 3));
    end

    build_model();

    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset_n     = !st_rst[k];
      bus.in_wr   = st_wr[k];
      bus.in_ctrl = st_ctrl[k];
      bus.in_data = st_data[k];
      @(posedge clk);
      #1;
      cyc = k;
      chk("port",     32'(out_port),  32'(e_port[k]));
      chk("len",      32'(len),       32'(e_len[k]));
      chk("proto",    32'(proto),     32'(e_proto[k]));
      chk("rtt",      32'(rtt),       32'(e_rtt[k]));
      chk("is_rcp",   32'(is_rcp),    32'(e_isrcp[k]));
      chk("port_vld", 32'(port_vld),  32'(e_pv[k]));
      chk("len_vld",  32'(len_vld),   32'(e_lv[k]));
      chk("prot_vld", 32'(proto_vld), 32'(e_prv[k]));
      chk("rtt_vld",  32'(rtt_vld),   32'(e_rv[k]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
